// File: rtl/rndx_gen.sv
// Multi-lane LFSR random word generator with a programmable update-rate divider.
// Each output bit comes from its own 32-bit lane seeded from a rotated base value.
module rndx_gen #(
    parameter int unsigned WIDTH    = 8,
    parameter logic [31:0] INIT_VAL = 32'h12345678,
    parameter int unsigned DIVW     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIVW-1:0]  div,
    input  logic             seed_we,
    input  logic [31:0]      seed,
    output logic [WIDTH-1:0] sout,
    output logic             strobe
);

    logic [31:0]     lane      [WIDTH];
    logic [31:0]     lane_next [WIDTH];
    logic [31:0]     lane_seed [WIDTH];
    logic [31:0]     base;
    logic [DIVW-1:0] cnt;
    logic            tick;

    // Lane i starts at the base rotated left by 3*i; a zero [30:0] would lock the LFSR.
    function automatic logic [31:0] derive_lane(input logic [31:0] b, input int unsigned idx);
        logic [63:0] dbl;
        logic [31:0] r;
        dbl = {b, b} << ((3 * idx) % 32);
        r   = dbl[63:32];
        if (r[30:0] == '0) begin
            r = 32'h0000_0001;
        end
        return r;
    endfunction

    always_comb begin
        base = rst ? INIT_VAL : seed;
        tick = en && (cnt >= div);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            lane_seed[i] = derive_lane(base, i);
            lane_next[i] = {lane[i][30:0], lane[i][30] ^ lane[i][27]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                lane[i] <= lane_seed[i];
            end
            cnt    <= '0;
            sout   <= '0;
            strobe <= 1'b0;
        end else if (seed_we) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                lane[i] <= lane_seed[i];
            end
            cnt    <= '0;
            strobe <= 1'b0;
        end else if (tick) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                sout[i] <= lane[i][5];
                lane[i] <= lane_next[i];
            end
            cnt    <= '0;
            strobe <= 1'b1;
        end else if (en) begin
            cnt    <= cnt + DIVW'(1);
            strobe <= 1'b0;
        end else begin
            strobe <= 1'b0;
        end
    end

endmodule

// File: doc/rndx_gen.md
RNDX_GEN -- requirements
Module: rndx_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning number of output bits (= LFSR lanes), legal 1..32.
REQ-002 SHALL have parameter INIT_VAL, default 32'h12345678, meaning base seed applied at reset.
REQ-003 SHALL have parameter DIVW, default 8, meaning width of the rate divider.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1, meaning advance enable; when low, all state holds.
REQ-007 SHALL have port div, input, DIVW, meaning update period minus one, in enabled cycles.
REQ-008 SHALL have port seed_we, input, 1, meaning single-cycle reseed request.
REQ-009 SHALL have port seed, input, 32, meaning base seed sampled when seed_we=1.
REQ-010 SHALL have port sout, output, WIDTH, meaning registered random word.
REQ-011 SHALL have port strobe, output, 1, meaning one-cycle pulse marking a new sout value.

Function
REQ-012 SHALL hold WIDTH independent 32-bit lanes L[i] plus a DIVW-bit counter cnt.
REQ-013 SHALL derive lane seeds from a base B: L[i] = B rotated left by (3*i mod 32) bits.
REQ-014 SHALL replace any derived lane whose bits [30:0] are all zero with 32'h00000001 (lock-up guard); this covers B = 0 and B = 32'h80000000.
REQ-015 SHALL define a tick as en=1 and cnt >= div, evaluated at the clock edge.
REQ-016 SHALL, on a tick, set cnt to 0 and step every lane: L[i] <= {L[i][30:0], L[i][30] ^ L[i][27]}.
REQ-017 SHALL, on a tick, set sout[i] <= pre-step L[i][5] for every i, and set strobe <= 1.
REQ-018 SHALL, on an enabled cycle without a tick, increment cnt by 1, hold lanes and sout, and set strobe <= 0.
REQ-019 SHALL, when en=0, hold cnt, lanes and sout, and set strobe <= 0.
REQ-020 SHALL use the >= compare so that lowering div below cnt produces a tick on the next enabled cycle, with no counter wrap.
REQ-021 SHALL, on seed_we=1, reload lanes from B = seed per REQ-013/014, set cnt to 0, hold sout, set strobe <= 0, and ignore en.
REQ-022 SHALL apply priority rst > seed_we > tick > count.
REQ-023 SHALL make strobe and sout change on the same edge; latency from the first enabled cycle after reset or reseed to the first strobe is div+1 cycles.
REQ-024 SHALL never drive a lane into the all-zero [30:0] state.

Reset
REQ-025 SHALL, while rst=1 at an edge: load lanes from B = INIT_VAL per REQ-013/014, set cnt=0, sout=0 and strobe=0.
REQ-026 SHALL ignore en and seed_we while rst=1.
REQ-027 SHALL, on reset asserted mid-period, discard the partial count.

Verification
REQ-028 SHALL check: WIDTH=8, rst then en=1, div=0 -> strobe every cycle; first sout[0]=1 (bit 5 of 32'h12345678); second lane-0 state 32'h2468ACF0, giving sout[0]=1.
REQ-029 SHALL check: div=3, en=1 continuous -> strobe high on exactly 1 cycle in 4, first at the 4th enabled cycle; sout stable between strobes.
REQ-030 SHALL check: seed_we with seed=32'h80000000 -> L[0]=32'h00000001 and L[1]=32'h00000004; with div=0, sout[0] is 0 for strobes 1-5 and 1 at strobe 6.
REQ-031 SHALL check: en toggling 1,0,0,1 with div=1 -> cnt and lanes frozen while en=0; strobe only after 2 enabled cycles in total.
REQ-032 SHALL check: div changed from 10 to 2 when cnt=7 -> tick on the next enabled cycle; then period 3.
REQ-033 SHALL check: rst and seed_we asserted together mid-period -> state equals the INIT_VAL reset state, with sout=0 and strobe=0.
